wishbone_bus_if: RTL

Wishbone B3 classic initiator that sits between an OpenMIPS memory port (instruction fetch or data access) and the shared Wishbone bus. It turns single-cycle CPU requests into registered Wishbone read and write cycles. While a cycle is outstanding it holds the pipeline with a stall request. It returns read data so it stays valid across pipeline stalls. A watchdog ends any cycle the responder never acknowledges.

---
 rtl/wishbone_bus_if_pkg.sv | 21 ++
 rtl/wishbone_bus_if.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/wishbone_bus_if_pkg.sv
// Shared definitions for the Wishbone B3 classic initiator: FSM encoding,
// bus widths and small decode helpers.
package wishbone_bus_if_pkg;

  localparam int REG_W   = 32;
  localparam int ADDR_W  = 32;
  localparam int SEL_W   = 4;
  localparam int STALL_W = 6;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    WB_IDLE           = 2'b00,
    WB_BUSY           = 2'b01,
    WB_WAIT_FOR_STALL = 2'b11
  } wb_state_t;

  function automatic logic pipe_stalled(input logic [STALL_W-1:0] stall);
    return |stall;
  endfunction

endpackage

// File: rtl/wishbone_bus_if.sv
// Wishbone B3 classic initiator between an OpenMIPS memory port and the bus.
// One cycle outstanding at most; a watchdog aborts unacknowledged cycles.
module wishbone_bus_if
  import wishbone_bus_if_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall_i,
  input  logic                flush_i,
  input  logic                cpu_ce_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [REG_W-1:0]    cpu_data_i,
  input  logic                cpu_we_i,
  input  logic [SEL_W-1:0]    cpu_sel_i,
  output logic [REG_W-1:0]    cpu_data_o,
  output logic                stallreq,
  output logic                bus_err_o,
  input  logic [REG_W-1:0]    wishbone_data_i,
  input  logic                wishbone_ack_i,
  output logic [ADDR_W-1:0]   wishbone_addr_o,
  output logic [REG_W-1:0]    wishbone_data_o,
  output logic                wishbone_we_o,
  output logic [SEL_W-1:0]    wishbone_sel_o,
  output logic                wishbone_stb_o,
  output logic                wishbone_cyc_o
);

  // Counter value in the BUSY cycle whose missing ack makes it reach TIMEOUT.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  wb_state_t           state;
  logic [CNT_W-1:0]    tmo_cnt;
  logic [REG_W-1:0]    rd_buf;
  logic                tmo_hit;
  logic                new_req;

  assign tmo_hit = (tmo_cnt == TMO_LAST);
  assign new_req = cpu_ce_i && !flush_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= WB_IDLE;
      tmo_cnt         <= '0;
      rd_buf          <= '0;
      bus_err_o       <= 1'b0;
      wishbone_addr_o <= '0;
      wishbone_data_o <= '0;
      wishbone_we_o   <= 1'b0;
      wishbone_sel_o  <= '0;
      wishbone_stb_o  <= 1'b0;
      wishbone_cyc_o  <= 1'b0;
    end else begin
      bus_err_o <= 1'b0;
      case (state)
        WB_IDLE: begin
          if (new_req) begin
            wishbone_addr_o <= cpu_addr_i;
            wishbone_data_o <= cpu_data_i;
            wishbone_we_o   <= cpu_we_i;
            wishbone_sel_o  <= cpu_sel_i;
            wishbone_stb_o  <= 1'b1;
            wishbone_cyc_o  <= 1'b1;
            tmo_cnt         <= '0;
            state           <= WB_BUSY;
          end
        end

        WB_BUSY: begin
          if (flush_i) begin
            wishbone_stb_o <= 1'b0;
            wishbone_cyc_o <= 1'b0;
            rd_buf         <= '0;
            state          <= WB_IDLE;
          end else if (wishbone_ack_i) begin
            wishbone_stb_o <= 1'b0;
            wishbone_cyc_o <= 1'b0;
            wishbone_we_o  <= 1'b0;
            wishbone_sel_o <= '0;
            if (!wishbone_we_o) begin
              rd_buf <= wishbone_data_i;
            end
            state <= pipe_stalled(stall_i) ? WB_WAIT_FOR_STALL : WB_IDLE;
          end else if (tmo_hit) begin
            // Abort: the responder never answered, hand back zero data.
            wishbone_stb_o <= 1'b0;
            wishbone_cyc_o <= 1'b0;
            rd_buf         <= '0;
            bus_err_o      <= 1'b1;
            state          <= pipe_stalled(stall_i) ? WB_WAIT_FOR_STALL : WB_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        WB_WAIT_FOR_STALL: begin
          if (flush_i) begin
            rd_buf <= '0;
            state  <= WB_IDLE;
          end else if (!pipe_stalled(stall_i)) begin
            state <= WB_IDLE;
          end
        end

        default: state <= WB_IDLE;
      endcase
    end
  end

  // Pipeline-facing outputs are decoded combinationally so the CPU sees ack
  // data and the stall release in the same cycle; reset forces them low.
  always_comb begin
    stallreq   = 1'b0;
    cpu_data_o = '0;
    if (rst) begin
      case (state)
        WB_IDLE: begin
          stallreq = new_req;
        end
        WB_BUSY: begin
          if (flush_i) begin
            stallreq = 1'b0;
          end else if (wishbone_ack_i) begin
            cpu_data_o = wishbone_we_o ? '0 : wishbone_data_i;
          end else if (!tmo_hit) begin
            stallreq = 1'b1;
          end
        end
        WB_WAIT_FOR_STALL: begin
          cpu_data_o = rd_buf;
        end
        default: begin
          stallreq   = 1'b0;
          cpu_data_o = '0;
        end
      endcase
    end
  end

endmodule
